// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential word fetch from a one-cycle imem into a
// small PC-tagged prefetch queue, drained to decode over valid/ready.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t             q_mem [DEPTH];
  logic [31:0]        fetch_pc;
  logic [31:0]        inflight_pc;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic               inflight;

  logic               has_room;
  logic               empty;
  logic               push;
  logic               pop;

  // Requests only consider queued plus in-flight words, so out_ready never reaches imem_req.
  always_comb begin
    has_room  = (SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH);
    empty     = (count == '0);
    imem_req  = reset & ~redirect & has_room;
    imem_addr = fetch_pc;
    out_valid = ~empty & ~redirect;
    out_pc    = empty ? 32'h0 : q_mem[head].pc;
    out_instr = empty ? 32'h0 : q_mem[head].instr;
    push      = inflight & ~redirect;
    pop       = out_valid & out_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      inflight    <= 1'b0;
    end else if (redirect) begin
      // Flush: any response landing this cycle is dropped with the queue.
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (reset && push) q_mem[tail] <= '{pc: inflight_pc, instr: imem_data};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-level reference model compared
// every cycle, plus literal expectations for the directed scenarios.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle latency, word = addr ^ KEY, junk otherwise.
  always @(posedge clk) imem_data <= imem_req ? (imem_addr ^ KEY) : $urandom();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of PCs, the next fetch address and one in-flight slot.
  logic [31:0] m_q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_ipc;
  bit          m_inf  = 1'b0;
  bit          m_init = 1'b0;
  logic [31:0] popped[$];

  function automatic bit m_req();
    return reset && !redirect && ((m_q.size() + int'(m_inf)) < int'(DEPTH));
  endfunction

  function automatic bit m_valid();
    return (m_q.size() != 0) && !redirect;
  endfunction

  always @(posedge clk) begin
    bit req;
    bit vld;
    req = m_req();
    vld = m_valid();
    if (!reset) begin
      m_q.delete();
      m_inf  = 1'b0;
      m_fpc  = RESET_PC;
      m_init = 1'b1;
    end else if (redirect) begin
      m_q.delete();
      m_inf = 1'b0;
      m_fpc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (vld && out_ready) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_ipc);
      m_inf = req;
      if (req) begin
        m_ipc = m_fpc;
        m_fpc = m_fpc + 32'd4;
      end
    end
  end

  // Compare every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("imem_req",  {31'b0, imem_req},  {31'b0, m_req()});
      chk("imem_addr", imem_addr,          m_fpc);
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid()});
      chk("out_pc",    out_pc,             (m_q.size() != 0) ? m_q[0] : 32'h0);
      chk("out_instr", out_instr,          (m_q.size() != 0) ? (m_q[0] ^ KEY) : 32'h0);
      if (out_valid && out_ready) popped.push_back(out_pc);
    end
  end

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b1;

    // Reset stream
    step(1);
    chk("rst_req",   {31'b0, imem_req},  32'h0);
    chk("rst_addr",  imem_addr,          RESET_PC);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_pc",    out_pc,             32'h0);
    chk("rst_instr", out_instr,          32'h0);
    step(2);
    reset = 1'b1;
    popped.delete();
    #1;
    chk("first_req",  {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr,         RESET_PC);
    step(1);
    chk("lat_valid0", {31'b0, out_valid}, 32'h0);
    step(1);
    chk("lat_valid1", {31'b0, out_valid}, 32'h1);
    chk("lat_pc0",    out_pc,             32'h0);
    chk("lat_instr0", out_instr,          KEY);
    step(1);
    chk("lat_pc4", out_pc, 32'h4);
    step(1);
    chk("lat_pc8", out_pc, 32'h8);

    // Backpressure
    out_ready = 1'b0;
    step(8);
    chk("bp_req",   {31'b0, imem_req},  32'h0);
    chk("bp_valid", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    step(12);

    // Push/pop at full with out_ready toggling
    out_ready = 1'b0;
    step(6);
    for (int i = 0; i < 16; i++) begin
      out_ready = ~out_ready;
      step(1);
    end
    out_ready = 1'b1;
    step(6);
    chk("stream_len", {31'b0, popped.size() >= 20}, 32'h1);
    foreach (popped[i]) chk("stream_order", popped[i], 32'(i) * 32'd4);

    // Redirect with 3 queued and 1 in flight
    out_ready = 1'b0;
    step(8);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("redir_valid", {31'b0, out_valid}, 32'h0);
    chk("redir_req",   {31'b0, imem_req},  32'h0);
    step(1);
    redirect = 1'b0;
    popped.delete();
    #1;
    chk("redir_addr",   imem_addr,          32'h0000_0100);
    chk("redir_req1",   {31'b0, imem_req},  32'h1);
    chk("redir_empty",  {31'b0, out_valid}, 32'h0);
    out_ready = 1'b1;
    step(1);
    chk("redir_valid0", {31'b0, out_valid}, 32'h0);
    step(1);
    chk("redir_valid1", {31'b0, out_valid}, 32'h1);
    chk("redir_pc",     out_pc,             32'h0000_0100);
    chk("redir_instr",  out_instr,          32'h0000_0100 ^ KEY);
    step(4);
    chk("redir_pops", {31'b0, popped.size() >= 4}, 32'h1);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      chk("redir_order", popped[i], 32'h0000_0100 + 32'(i) * 32'd4);

    // Address wrap via a held redirect; the last redirect_pc wins, low bits ignored
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    step(1);
    redirect_pc = 32'hFFFF_FFFA;
    step(2);
    redirect = 1'b0;
    popped.delete();
    step(8);
    chk("wrap_pops", {31'b0, popped.size() >= 4}, 32'h1);
    if (popped.size() >= 4) begin
      chk("wrap_pc0", popped[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", popped[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", popped[2], 32'h0000_0000);
      chk("wrap_pc3", popped[3], 32'h0000_0004);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      out_ready   = (i % 64 < 32) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom();
      step(1);
    end
    redirect = 1'b0;

    // Reset mid-operation: 2 queued, 1 in flight
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step(1);
    redirect  = 1'b0;
    out_ready = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    chk("mrst_req",   {31'b0, imem_req},  32'h0);
    chk("mrst_addr",  imem_addr,          RESET_PC);
    chk("mrst_valid", {31'b0, out_valid}, 32'h0);
    chk("mrst_pc",    out_pc,             32'h0);
    chk("mrst_instr", out_instr,          32'h0);
    reset     = 1'b1;
    out_ready = 1'b1;
    popped.delete();
    step(6);
    chk("mrst_pops", {31'b0, popped.size() >= 2}, 32'h1);
    if (popped.size() >= 2) begin
      chk("mrst_pc0", popped[0], RESET_PC);
      chk("mrst_pc1", popped[1], RESET_PC + 32'd4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage with a small prefetch queue. It sits between the program-counter/instruction-memory pair and instruction decode. It generates sequential word addresses, issues reads to a one-cycle-latency instruction memory, and buffers returned words with their PCs. It hands them to decode over a valid/ready handshake, and flushes cleanly on a branch/jump redirect.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low; 0 at a rising edge resets the block.
- redirect  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
- imem_req  output  1  read request to instruction memory this cycle.
- imem_addr  output  32  word-aligned read address.
- imem_data  input  32  read data; valid in the cycle after the cycle imem_req was high.
- out_valid  output  1  head entry available to decode.
- out_instr  output  32  head instruction word.
- out_pc  output  32  address of the head instruction.
- out_ready  input  1  decode accepts the head entry.

## Operation
- State:
  - fetch_pc (32b);
  - queue storage of DEPTH × {pc, instr};
  - head/tail pointers (log2 DEPTH bits, wrapping);
  - count (log2 DEPTH + 1 bits);
  - inflight (1b) plus the PC of the in-flight request.
- Reset (reset=0 at an edge):
  - fetch_pc = RESET_PC; count = 0; head = tail = 0; inflight = 0.
  - Outputs during and after reset until the next event: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- Request rule (combinational from registered state only; must not depend on out_ready):
  - imem_req = reset & ~redirect & (count + inflight < DEPTH).
  - imem_addr = fetch_pc.
  - When imem_req is high, at the edge: fetch_pc += 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0); inflight = 1; the in-flight PC records imem_addr. Otherwise inflight = 0.
- Response: if inflight=1 and no redirect this cycle, {inflight pc, imem_data} is written at tail and tail advances. The room check guarantees no overflow.
- Output:
  - out_valid = (count != 0) & ~redirect.
  - out_instr and out_pc come from the head entry; they are 0 when count=0.
  - Pop occurs when out_valid & out_ready; head advances.
- Push and pop in the same cycle: count is unchanged; both pointers advance.
- Redirect (priority over everything except reset):
  - At the edge: count = 0; head = tail = 0; inflight = 0; fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Any response arriving in the redirect cycle is discarded.
  - No pop occurs, because out_valid is forced to 0.
- Redirect held high for several cycles: the block stays flushed; fetch resumes the cycle after redirect drops, using the last redirect_pc.
- Reset asserted mid-operation, including with a request in flight: the stale response is discarded because inflight=0 after reset.

## Timing
- The first edge with reset=1 samples the first request (RESET_PC). Data returns during the next cycle, is pushed at the following edge, and out_valid rises after that: 2 edges from the first request to out_valid.
- Steady-state throughput: 1 instruction/cycle whenever out_ready stays high and DEPTH ≥ 2.
- Redirect: the first request to redirect_pc is issued the cycle after redirect is high. The first redirected instruction becomes visible 2 edges after that.
- Backpressure:
  - With out_ready=0, the queue fills to exactly DEPTH entries and imem_req drops once count + inflight = DEPTH.
  - No word is lost or duplicated.
  - Requests resume the cycle after a pop lowers count.
- All outputs are glitch-free functions of registered state plus redirect. There is no combinational path from out_ready to imem_req.

## Test plan
- Reset stream: hold reset=0 for 3 cycles, then release; memory returns instr = addr ^ 32'hA5A5_0000; out_ready=1. Required: out_pc sequence 0, 4, 8, 12… on consecutive cycles starting 2 edges after release, each with matching instr.
- Backpressure: out_ready=0 after streaming starts. Required: count saturates at 4; imem_req=0 while full; on release, out_pc continues with no gaps or duplicates.
- Redirect: redirect=1 for one cycle with redirect_pc=32'h0000_0103 while 3 entries are queued and 1 is in flight. Required: out_valid=0 in the redirect cycle; the queue is empty; the next imem_addr is 32'h0000_0100; the next out_pc is 32'h100; the stale response never appears.
- Wrap-around: RESET_PC=32'hFFFF_FFF8. Required: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Simultaneous push/pop at full: DEPTH=4, full queue, out_ready toggling 1/0 each cycle. Required: count never exceeds 4; ordering is preserved; imem_req is high only when count + inflight < 4.
- Reset mid-operation: assert reset=0 for one edge while a request is in flight and the queue is half full. Required: all outputs return to their reset values; no stale word is output; fetch restarts at RESET_PC.
